// File: rtl/npu_pkg.sv
// Shared lane geometry and collector state encoding for the npu_simple result path.
package npu_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDone
  } coll_state_e;

endpackage

// File: rtl/npu_out_collector_if.sv
// Result-stream, host read port and status bundle of the output collector.
// The checksum signal exists only when NPU_OUT_CHECKSUM_EN is defined.
interface npu_out_collector_if #(
  parameter int unsigned ADDR_W = 12
);
  import npu_pkg::*;

  logic                    start;
  logic [LANES*DATA_W-1:0] out;
  logic [LANES-1:0]        out_en;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_valid;
  logic                    busy;
  logic                    band_done;
  logic                    frame_done;
  logic                    overflow;
`ifdef NPU_OUT_CHECKSUM_EN
  logic [15:0]             checksum;
`endif

  modport master (
`ifdef NPU_OUT_CHECKSUM_EN
    input  checksum,
`endif
    output start, out, out_en, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, band_done, frame_done, overflow
  );

  modport slave (
`ifdef NPU_OUT_CHECKSUM_EN
    output checksum,
`endif
    input  start, out, out_en, rd_en, rd_addr,
    output rd_data, rd_valid, busy, band_done, frame_done, overflow
  );

endinterface

// File: rtl/npu_out_bank.sv
// One lane's slice of the output feature map: 1 write + 1 registered read port,
// a read colliding with a write returns the previous contents.
module npu_out_bank
  import npu_pkg::*;
#(
  parameter int unsigned Depth = 512,
  parameter int unsigned AddrW = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AddrW-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AddrW-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/npu_out_collector.sv
// Collects the 8 npu output lanes into a lane-banked feature-map RAM, tracks band/frame
// completion and serves host reads. Optional running checksum: NPU_OUT_CHECKSUM_EN.
module npu_out_collector
  import npu_pkg::*;
#(
  parameter int unsigned OUT_WIDTH  = 64,
  parameter int unsigned OUT_HEIGHT = 64,
  parameter int unsigned ADDR_W     = 12
) (
  input logic                clk,
  input logic                reset,
  npu_out_collector_if.slave bus
);

  localparam int unsigned NumBands  = OUT_HEIGHT / LANES;
  localparam int unsigned BandW     = (NumBands > 1) ? $clog2(NumBands) : 1;
  localparam int unsigned ColW      = $clog2(OUT_WIDTH + 1);
  localparam int unsigned BankDepth = OUT_WIDTH * NumBands;
  localparam int unsigned BankAw    = $clog2(BankDepth);
  localparam int unsigned FrameSize = OUT_WIDTH * OUT_HEIGHT;
  localparam int unsigned LaneW     = $clog2(LANES);
  localparam logic [ColW-1:0]  ColFull  = ColW'(OUT_WIDTH);
  localparam logic [BandW-1:0] LastBand = BandW'(NumBands - 1);

  coll_state_e       state_q, state_d;
  logic [BandW-1:0]  band_q, band_d;
  logic [ColW-1:0]   col_q [LANES];
  logic [ColW-1:0]   col_d [LANES];
  logic              overflow_q, overflow_d;
  logic              all_full, band_pulse, last_band;

  logic              lane_en   [LANES];
  logic [DATA_W-1:0] lane_data [LANES];
  logic              we        [LANES];
  logic [BankAw-1:0] waddr     [LANES];
  logic              re        [LANES];
  logic [DATA_W-1:0] bank_rdata [LANES];

  int unsigned       rd_int, rd_row;
  logic              rd_oob;
  logic [LaneW-1:0]  rd_sel;
  logic [BankAw-1:0] rd_baddr;
  logic              rd_valid_q, rd_oob_q;
  logic [LaneW-1:0]  rd_sel_q;

`ifdef NPU_OUT_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  always_comb begin
    all_full = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      lane_en[l]   = bus.out_en[LANES-1-l];
      lane_data[l] = bus.out[(LANES-1-l)*DATA_W +: DATA_W];
      if (col_q[l] != ColFull) all_full = 1'b0;
    end
    band_pulse = (state_q == StCollect) && all_full;
    last_band  = (band_q == LastBand);

    state_d    = state_q;
    band_d     = band_q;
    col_d      = col_q;
    overflow_d = overflow_q;
`ifdef NPU_OUT_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    for (int l = 0; l < LANES; l++) begin
      we[l] = 1'b0;
    end

    if (bus.start) begin
      state_d    = StCollect;
      band_d     = '0;
      overflow_d = 1'b0;
      for (int l = 0; l < LANES; l++) col_d[l] = '0;
`ifdef NPU_OUT_CHECKSUM_EN
      sum_d      = '0;
`endif
    end else if (state_q == StCollect) begin
      if (band_pulse) begin
        for (int l = 0; l < LANES; l++) col_d[l] = '0;
        if (last_band) state_d = StDone;
        else           band_d  = band_q + 1'b1;
      end
      // In a band-done cycle the counters are clearing, so arrivals land in column 0
      // of the next band; after the final band there is nowhere to put them.
      for (int l = 0; l < LANES; l++) begin
        if (lane_en[l] && !(band_pulse && last_band)) begin
          if (band_pulse) begin
            we[l]    = 1'b1;
            col_d[l] = ColW'(1);
          end else if (col_q[l] != ColFull) begin
            we[l]    = 1'b1;
            col_d[l] = col_q[l] + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
`ifdef NPU_OUT_CHECKSUM_EN
          if (we[l]) sum_d = sum_d + 16'(lane_data[l]);
`endif
        end
      end
    end

    for (int l = 0; l < LANES; l++) begin
      waddr[l] = BankAw'(32'(band_d) * OUT_WIDTH + (band_pulse ? 32'd0 : 32'(col_q[l])));
    end
  end

  always_comb begin
    rd_int   = 32'(bus.rd_addr);
    rd_row   = rd_int / OUT_WIDTH;
    rd_oob   = (rd_int >= FrameSize);
    rd_sel   = LaneW'(rd_row % LANES);
    rd_baddr = BankAw'((rd_row / LANES) * OUT_WIDTH + rd_int % OUT_WIDTH);
    for (int l = 0; l < LANES; l++) begin
      re[l] = bus.rd_en && !rd_oob && (rd_sel == LaneW'(l));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      band_q     <= '0;
      col_q      <= '{default: '0};
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_sel_q   <= '0;
    end else begin
      state_q    <= state_d;
      band_q     <= band_d;
      col_q      <= col_d;
      overflow_q <= overflow_d;
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_oob_q <= rd_oob;
        rd_sel_q <= rd_sel;
      end
    end
  end

`ifdef NPU_OUT_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end
  assign bus.checksum = sum_q;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    npu_out_bank #(
      .Depth (BankDepth),
      .AddrW (BankAw)
    ) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (we[g]),
      .waddr (waddr[g]),
      .wdata (lane_data[g]),
      .re    (re[g]),
      .raddr (rd_baddr),
      .rdata (bank_rdata[g])
    );
  end

  assign bus.rd_data    = rd_oob_q ? '0 : bank_rdata[rd_sel_q];
  assign bus.rd_valid   = rd_valid_q;
  assign bus.busy       = (state_q == StCollect);
  assign bus.band_done  = band_pulse;
  assign bus.frame_done = band_pulse && last_band;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_npu_out_collector.sv
// Self-checking bench for npu_out_collector; read results go through an expectation queue.
module tb_npu_out_collector;
  import npu_pkg::*;

  localparam int unsigned AW = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   bd_cnt = 0;
  int   fd_cnt = 0;
  int   bd_base;
  int   fd_base;
  logic [7:0]  exp_q [$];
  logic [7:0]  ex;
  logic [63:0] d;

  npu_out_collector_if #(.ADDR_W(AW)) bus ();

  npu_out_collector #(
    .OUT_WIDTH  (64),
    .OUT_HEIGHT (64),
    .ADDR_W     (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int row, input int col);
    return 8'(row * 4 + col * 7);
  endfunction

  // Drive one cycle of lane data and an optional read, then step to #1 after the edge.
  task automatic cyc(input logic [7:0] en, input logic [63:0] data, input logic re,
                     input int ra, input int exv);
    bus.out_en  = en;
    bus.out     = data;
    bus.rd_en   = re;
    bus.rd_addr = AW'(ra);
    if (re) exp_q.push_back(8'(exv));
    @(posedge clk);
    #1;
    bus.out_en = '0;
    bus.rd_en  = 1'b0;
  endtask

  task automatic rd(input int ra, input int exv);
    cyc(8'h00, 64'h0, 1'b1, ra, exv);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Continuous all-lane stream; mode 0 = pat(row,col), mode 1 = constant 8'h01.
  task automatic stream(input int n, input int mode);
    logic [63:0] sd;
    for (int k = 0; k < n; k++) begin
      sd = '0;
      for (int l = 0; l < 8; l++) begin
        sd[(7-l)*8 +: 8] = (mode == 1) ? 8'h01 : pat((k / 64) * 8 + l, k % 64);
      end
      cyc(8'hFF, sd, 1'b0, 0, 0);
    end
  endtask

  always @(negedge clk) begin
    if (bus.band_done)  bd_cnt++;
    if (bus.frame_done) fd_cnt++;
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'(bus.rd_valid), 0);
      end else begin
        ex = exp_q.pop_front();
        chk("rd_data", 32'(bus.rd_data), 32'(ex));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.start   = 1'b0;
    bus.out     = '0;
    bus.out_en  = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    #12;
    chk("rst_busy",     32'(bus.busy), 0);
    chk("rst_band",     32'(bus.band_done), 0);
    chk("rst_frame",    32'(bus.frame_done), 0);
    chk("rst_ovf",      32'(bus.overflow), 0);
    chk("rst_rdvalid",  32'(bus.rd_valid), 0);
    chk("rst_rddata",   32'(bus.rd_data), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single band, lane L byte = L*16+col.
    pulse_start();
    chk("t1_busy", 32'(bus.busy), 1);
    for (int c = 0; c < 64; c++) begin
      chk("t1_nodone", 32'(bus.band_done), 0);
      d = '0;
      for (int l = 0; l < 8; l++) d[(7-l)*8 +: 8] = 8'(l * 16 + c);
      cyc(8'hFF, d, 1'b0, 0, 0);
    end
    chk("t1_band_done", 32'(bus.band_done), 1);
    chk("t1_no_frame",  32'(bus.frame_done), 0);
    cyc(8'h00, 64'h0, 1'b0, 0, 0);
    chk("t1_pulse_1cyc", 32'(bus.band_done), 0);
    rd(3 * 64 + 10, 8'h3A);

    // Full frame streamed back to back.
    pulse_start();
    bd_base = bd_cnt;
    fd_base = fd_cnt;
    stream(512, 0);
    chk("t2_last_band",  32'(bus.band_done), 1);
    chk("t2_frame_done", 32'(bus.frame_done), 1);
    chk("t2_busy_hold",  32'(bus.busy), 1);
    cyc(8'h00, 64'h0, 1'b0, 0, 0);
    chk("t2_busy_fall",  32'(bus.busy), 0);
    chk("t2_band_count", 32'(bd_cnt - bd_base), 8);
    chk("t2_frame_count", 32'(fd_cnt - fd_base), 1);
    cyc(8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0);
    chk("t2_done_no_ovf", 32'(bus.overflow), 0);
    rd(0, pat(0, 0));
    rd(63 * 64 + 63, pat(63, 63));
    rd(8 * 64 + 5, pat(8, 5));
    rd(27 * 64 + 40, pat(27, 40));

    // Skewed lanes.
    pulse_start();
    for (int c = 0; c < 63; c++) cyc(8'hFF, 64'h0, 1'b0, 0, 0);
    cyc(8'h80, 64'h0, 1'b0, 0, 0);
    chk("t3_skew_nodone", 32'(bus.band_done), 0);
    cyc(8'h00, 64'h0, 1'b0, 0, 0);
    chk("t3_skew_nodone2", 32'(bus.band_done), 0);
    cyc(8'h7F, 64'h0, 1'b0, 0, 0);
    chk("t3_skew_done", 32'(bus.band_done), 1);
    chk("t3_skew_no_ovf", 32'(bus.overflow), 0);

    // Lane 2 overfed.
    pulse_start();
    for (int c = 0; c < 64; c++) begin
      d = '0;
      d[(7-2)*8 +: 8] = 8'(c);
      cyc(8'h20, d, 1'b0, 0, 0);
    end
    chk("t4_no_ovf_yet", 32'(bus.overflow), 0);
    d = '0;
    d[(7-2)*8 +: 8] = 8'h40;
    cyc(8'h20, d, 1'b0, 0, 0);
    chk("t4_ovf_set", 32'(bus.overflow), 1);
    for (int i = 0; i < 3; i++) cyc(8'h00, 64'h0, 1'b0, 0, 0);
    chk("t4_ovf_sticky", 32'(bus.overflow), 1);
    rd(2 * 64 + 63, 8'h3F);
    pulse_start();
    chk("t4_ovf_clear", 32'(bus.overflow), 0);

    // Same-cycle read/write on address 5 returns the old byte.
    for (int c = 0; c < 6; c++) begin
      d = '0;
      d[63:56] = (c == 5) ? 8'h11 : 8'(c);
      cyc(8'h80, d, 1'b0, 0, 0);
    end
    pulse_start();
    for (int c = 0; c < 5; c++) cyc(8'h80, 64'h5500_0000_0000_0000, 1'b0, 0, 0);
    cyc(8'h80, 64'hAA00_0000_0000_0000, 1'b1, 5, 8'h11);
    rd(5, 8'hAA);
    rd(4096, 8'h00);
    chk("t5_oob_valid", 32'(bus.rd_valid), 1);
    cyc(8'h00, 64'h0, 1'b0, 0, 0);
    chk("t5_valid_drop", 32'(bus.rd_valid), 0);

    // Reset in the middle of band 1, then a clean all-ones frame.
    pulse_start();
    stream(64 + 30, 0);
    rd(8 * 64 + 3, pat(8, 3));
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_rst_busy",    32'(bus.busy), 0);
    chk("t6_rst_band",    32'(bus.band_done), 0);
    chk("t6_rst_frame",   32'(bus.frame_done), 0);
    chk("t6_rst_ovf",     32'(bus.overflow), 0);
    chk("t6_rst_rdvalid", 32'(bus.rd_valid), 0);
    chk("t6_rst_rddata",  32'(bus.rd_data), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t6_idle_busy", 32'(bus.busy), 0);
    pulse_start();
    stream(512, 1);
    chk("t6_frame_done", 32'(bus.frame_done), 1);
`ifdef NPU_OUT_CHECKSUM_EN
    chk("t6_checksum", 32'(bus.checksum), 4096);
`endif
    cyc(8'h00, 64'h0, 1'b0, 0, 0);
    chk("t6_busy_fall", 32'(bus.busy), 0);
`ifdef NPU_OUT_CHECKSUM_EN
    chk("t6_checksum_stable", 32'(bus.checksum), 4096);
`endif
    rd(45 * 64 + 17, 8'h01);

    cyc(8'h00, 64'h0, 1'b0, 0, 0);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
